// File: rtl/pe_row_sequencer_pkg.sv
// Shared encodings for the sparse 1-D convolution PE row sequencer:
// FSM states, compressed-word field positions and PE handshake levels.
package pe_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_W = 3'd1,
      S_HDR    = 3'd2,
      S_STREAM = 3'd3,
      S_FLUSH  = 3'd4,
      S_DONE   = 3'd5
   } seq_state_t;

   // Compressed input word: [15:8] index (or header nnz count), [7:0] value
   localparam int WORD_W  = 16;
   localparam int IDX_MSB = 15;
   localparam int IDX_LSB = 8;
   localparam int VAL_MSB = 7;

   // Levels shared with the PE top for advance-enable and end-of-row flush
   localparam logic PE_EN_ACTIVE = 1'b1;
   localparam logic FLUSH_ACTIVE = 1'b1;

   // States in which the PE consumes a word and out_ready applies
   function automatic logic is_pe_state(input seq_state_t s);
      return (s == S_HDR) || (s == S_STREAM) || (s == S_FLUSH);
   endfunction

endpackage

// File: rtl/pe_rd_addr_gen.sv
// Input-memory read address counter: loadable, hold-able, wraps modulo
// 2^ADDR_WIDTH. The suppress input skips one increment so the next header
// address can be presented twice (last data cycle and flush cycle).
module pe_rd_addr_gen #(
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_load,
   input  logic [ADDR_WIDTH-1:0] i_load_addr,
   input  logic                  i_en,
   input  logic                  i_suppress,
   output logic [ADDR_WIDTH-1:0] o_addr
);

   logic [ADDR_WIDTH-1:0] r_addr;

   // Load on accepted start, otherwise advance on enabled non-suppressed cycles
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_addr <= '0;
      end else if (i_load) begin
         r_addr <= i_load_addr;
      end else if (i_en && !i_suppress) begin
         r_addr <= r_addr + 1'b1;
      end
   end

   assign o_addr = r_addr;

endmodule

// File: rtl/pe_row_sequencer.sv
// Row-level controller for the sparse 1-D convolution PE: walks the
// compressed input rows (header + nonzeros), drives the PE word and cycle
// index, issues the per-row flush and honours back-pressure from the unfold.
module pe_row_sequencer
   import pe_seq_pkg::*;
#(
   parameter int ROW_LENGTH    = 28,
   parameter int FILTER_SIZE   = 5,
   parameter int ADDR_WIDTH_IN = 5,
   parameter int ADDR_WIDTH_W  = 5,
   parameter int CNT_WIDTH     = 5
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_start,
   input  logic [ADDR_WIDTH_IN-1:0] i_in_base,
   input  logic [ADDR_WIDTH_W-1:0]  i_w_base,
   input  logic [CNT_WIDTH-1:0]     i_num_rows,
   output logic [ADDR_WIDTH_IN-1:0] o_mem_in_addr,
   input  logic [WORD_W-1:0]        i_mem_in_data,
   output logic [ADDR_WIDTH_W-1:0]  o_mem_w_addr,
   input  logic                     i_out_ready,
   output logic [WORD_W-1:0]        o_pe_in,
   output logic [CNT_WIDTH-1:0]     o_pe_cnt,
   output logic                     o_pe_en,
   output logic                     o_row_fini,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_err
);

   // The filter width only matters to the PE and unfold stage
   if (FILTER_SIZE < 1) begin : g_bad_filter
      $error("FILTER_SIZE must be at least 1");
   end

   localparam logic [7:0] NNZ_MAX = 8'(ROW_LENGTH);

   seq_state_t               r_state, w_next;
   logic [7:0]               r_nnz;
   logic [CNT_WIDTH-1:0]     r_pe_cnt;
   logic [CNT_WIDTH-1:0]     r_rows_left;
   logic [ADDR_WIDTH_W-1:0]  r_w_addr;
   logic                     r_err;
   logic [WORD_W-1:0]        r_hold_data;
   logic                     r_hold_vld;

   logic [ADDR_WIDTH_IN-1:0] w_rd_addr;
   logic [WORD_W-1:0]        w_word;
   logic [7:0]               w_hdr_raw;
   logic                     w_hdr_ovf;
   logic [7:0]               w_hdr_nnz;
   logic                     w_load;
   logic                     w_adv;
   logic                     w_last;
   logic                     w_addr_en;
   logic                     w_addr_sup;

   // A stall keeps the address frozen, but memory keeps returning the word
   // for that address, i.e. the NEXT word. The word seen on the first stall
   // cycle is held so the PE sees the same word until the cycle completes.
   assign w_word    = r_hold_vld ? r_hold_data : i_mem_in_data;
   assign w_hdr_raw = w_word[IDX_MSB:IDX_LSB];
   assign w_hdr_ovf = (w_hdr_raw > NNZ_MAX);
   assign w_hdr_nnz = w_hdr_ovf ? NNZ_MAX : w_hdr_raw;

   assign w_load = (r_state == S_IDLE) && i_start;
   assign w_adv  = is_pe_state(r_state) && i_out_ready;
   assign w_last = (r_state == S_STREAM) && (r_pe_cnt == CNT_WIDTH'(r_nnz + 8'd1));

   pe_rd_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH_IN)
   ) u_rd_addr (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_load      (w_load),
      .i_load_addr (i_in_base),
      .i_en        (w_addr_en),
      .i_suppress  (w_addr_sup),
      .o_addr      (w_rd_addr)
   );

   // FSM state register
   always_ff @(posedge i_clk) begin
      if (!i_rst) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next state and address-counter control
   always_comb begin
      w_next     = r_state;
      w_addr_en  = 1'b0;
      w_addr_sup = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) w_next = (i_num_rows == '0) ? S_DONE : S_LOAD_W;
         end
         S_LOAD_W: begin
            w_addr_en = 1'b1;
            w_next    = S_HDR;
         end
         S_HDR: begin
            if (w_adv) begin
               w_addr_en = 1'b1;
               if (w_hdr_nnz == 8'd0) begin
                  w_addr_sup = 1'b1;
                  w_next     = S_FLUSH;
               end else begin
                  w_next = S_STREAM;
               end
            end
         end
         S_STREAM: begin
            if (w_adv) begin
               w_addr_en = 1'b1;
               if (w_last) begin
                  w_addr_sup = 1'b1;
                  w_next     = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            if (w_adv) begin
               w_addr_en = 1'b1;
               w_next    = (r_rows_left <= CNT_WIDTH'(1)) ? S_DONE : S_HDR;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Row bookkeeping: weight address, rows left, nnz, cycle index, error, stall hold
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_w_addr    <= '0;
         r_rows_left <= '0;
         r_nnz       <= '0;
         r_pe_cnt    <= '0;
         r_err       <= 1'b0;
         r_hold_data <= '0;
         r_hold_vld  <= 1'b0;
      end else begin
         if (w_load) begin
            r_w_addr    <= i_w_base;
            r_rows_left <= i_num_rows;
            r_err       <= 1'b0;
         end
         if ((r_state == S_HDR) && w_hdr_ovf) r_err <= 1'b1;
         if ((r_state == S_HDR) && w_adv)     r_nnz <= w_hdr_nnz;
         if ((r_state == S_FLUSH) && w_adv)   r_rows_left <= r_rows_left - 1'b1;

         case (r_state)
            S_LOAD_W:        r_pe_cnt <= CNT_WIDTH'(1);
            S_HDR, S_STREAM: if (w_adv) r_pe_cnt <= r_pe_cnt + 1'b1;
            S_FLUSH:         if (w_adv) r_pe_cnt <= (w_next == S_HDR) ? CNT_WIDTH'(1) : '0;
            default:         r_pe_cnt <= '0;
         endcase

         if (is_pe_state(r_state) && !i_out_ready) begin
            if (!r_hold_vld) r_hold_data <= i_mem_in_data;
            r_hold_vld <= 1'b1;
         end else begin
            r_hold_vld <= 1'b0;
         end
      end
   end

   // PE-facing outputs
   always_comb begin
      o_pe_in = '0;
      if ((r_state == S_HDR) || (r_state == S_STREAM))
         o_pe_in = {w_word[IDX_MSB:IDX_LSB], w_word[VAL_MSB:0]};
      o_pe_en    = w_adv ? PE_EN_ACTIVE : ~PE_EN_ACTIVE;
      o_row_fini = ((r_state == S_FLUSH) && i_out_ready) ? FLUSH_ACTIVE : ~FLUSH_ACTIVE;
      o_busy     = (r_state != S_IDLE);
      o_done     = (r_state == S_DONE);
      o_err      = r_err | ((r_state == S_HDR) && w_hdr_ovf);
   end

   assign o_pe_cnt      = r_pe_cnt;
   assign o_mem_in_addr = w_rd_addr;
   assign o_mem_w_addr  = r_w_addr;

endmodule

// File: tb/tb_pe_row_sequencer.sv
// Bench for pe_row_sequencer: a synchronous 1-cycle input memory, directed
// scenarios and randomized jobs, checked against a row-walk reference model.
module tb_pe_row_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  in_base = '0;
   logic [4:0]  w_base = '0;
   logic [4:0]  num_rows = '0;
   logic [4:0]  mem_in_addr;
   logic [15:0] mem_in_data = '0;
   logic [4:0]  mem_w_addr;
   logic        out_ready = 1'b1;
   logic [15:0] pe_in;
   logic [4:0]  pe_cnt;
   logic        pe_en, row_fini, busy, done, err;

   int n_checks = 0;
   int n_pass   = 0;

   logic [15:0] mem [0:31];

   typedef struct packed {
      logic [15:0] pin;
      logic [4:0]  cnt;
      logic [4:0]  addr;
      logic        fini;
      logic        err;
   } ev_t;

   ev_t  exp_q[$];
   int   exp_cost;
   logic exp_err;

   pe_row_sequencer dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_start       (start),
      .i_in_base     (in_base),
      .i_w_base      (w_base),
      .i_num_rows    (num_rows),
      .o_mem_in_addr (mem_in_addr),
      .i_mem_in_data (mem_in_data),
      .o_mem_w_addr  (mem_w_addr),
      .i_out_ready   (out_ready),
      .o_pe_in       (pe_in),
      .o_pe_cnt      (pe_cnt),
      .o_pe_en       (pe_en),
      .o_row_fini    (row_fini),
      .o_busy        (busy),
      .o_done        (done),
      .o_err         (err)
   );

   always #5 clk = ~clk;

   // Input memory with one cycle of read latency
   always @(posedge clk) mem_in_data <= mem[mem_in_addr];

   // Reference: every PE cycle of a job, walking the rows as stored in memory
   function automatic void build_exp(input logic [4:0] base, input logic [4:0] rows);
      logic [4:0] a;
      int         n;
      ev_t        ev;
      exp_q.delete();
      exp_cost = 0;
      exp_err  = 1'b0;
      a = base;
      for (int r = 0; r < int'(rows); r++) begin
         n = int'(mem[a][15:8]);
         if (n > 28) begin
            n = 28;
            exp_err = 1'b1;
         end
         ev.pin = mem[a]; ev.cnt = 5'd1; ev.addr = 5'(a + 1);
         ev.fini = 1'b0;  ev.err = exp_err;
         exp_q.push_back(ev);
         for (int k = 1; k <= n; k++) begin
            ev.pin = mem[5'(a + k)]; ev.cnt = 5'(k + 1); ev.addr = 5'(a + 1 + k);
            exp_q.push_back(ev);
         end
         ev.pin = 16'h0; ev.cnt = 5'(n + 2); ev.addr = 5'(a + 1 + n); ev.fini = 1'b1;
         exp_q.push_back(ev);
         a = 5'(a + 1 + n);
         exp_cost += n + 2;
      end
   endfunction

   // One start..done job; stalls are random (pct) and/or a fixed window
   task automatic run_job(input logic [4:0] base, input logic [4:0] wb, input logic [4:0] rows,
                          input int stall_pct, input int stall_at, input int stall_len,
                          input bit poke_start);
      int  cyc, stalls, exp_done;
      bit  got_done;
      ev_t ev;
      build_exp(base, rows);
      @(negedge clk);
      in_base = base; w_base = wb; num_rows = rows; start = 1'b1; out_ready = 1'b1;
      #1;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL idle_before_start: busy=%b want 0", busy);
      else n_pass++;
      @(negedge clk);
      cyc = 1; stalls = 0; got_done = 1'b0;
      while (!got_done && cyc < 400) begin
         start = poke_start && (cyc == 3);
         if (start) begin
            in_base = base ^ 5'h15; w_base = ~wb; num_rows = 5'($urandom_range(0, 31));
         end
         out_ready = 1'b1;
         if (cyc >= 2 && int'($urandom_range(0, 99)) < stall_pct) out_ready = 1'b0;
         if (cyc >= stall_at && cyc < stall_at + stall_len) out_ready = 1'b0;
         #1;
         n_checks++;
         if (mem_w_addr !== wb) $display("FAIL w_addr cyc%0d: got %h want %h", cyc, mem_w_addr, wb);
         else n_pass++;
         if (done === 1'b1) begin
            got_done = 1'b1;
            // inclusive count from the start cycle to the done cycle
            exp_done = (rows == 0) ? 2 : 2 + exp_cost + 1 + stalls;
            n_checks++;
            if (cyc + 1 != exp_done) $display("FAIL done_latency: got %0d want %0d", cyc + 1, exp_done);
            else n_pass++;
            n_checks++;
            if ({row_fini, pe_en, err, busy} !== {1'b0, 1'b0, exp_err, 1'b1})
               $display("FAIL done_cycle: fini/en/err/busy=%b%b%b%b want 00%b1",
                        row_fini, pe_en, err, busy, exp_err);
            else n_pass++;
            n_checks++;
            if (exp_q.size() != 0) $display("FAIL rows_cut_short: %0d cycles left want 0", exp_q.size());
            else n_pass++;
         end else if (cyc == 1) begin
            n_checks++;
            if ({pe_en, row_fini, busy, err, mem_in_addr, pe_in} !== {3'b001, 1'b0, base, 16'h0})
               $display("FAIL load_w: en/fini/busy/err=%b%b%b%b addr=%h pe_in=%h want 0010 addr=%h pe_in=0000",
                        pe_en, row_fini, busy, err, mem_in_addr, pe_in, base);
            else n_pass++;
         end else if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL overrun cyc%0d: no done after last flush", cyc);
         end else begin
            ev = exp_q[0];
            n_checks++;
            if ({pe_in, pe_cnt, mem_in_addr, err} !== {ev.pin, ev.cnt, ev.addr, ev.err})
               $display("FAIL pe_cycle cyc%0d: pe_in=%h cnt=%0d addr=%0d err=%b want pe_in=%h cnt=%0d addr=%0d err=%b",
                        cyc, pe_in, pe_cnt, mem_in_addr, err, ev.pin, ev.cnt, ev.addr, ev.err);
            else n_pass++;
            n_checks++;
            if ({pe_en, row_fini, busy} !== {out_ready, out_ready & ev.fini, 1'b1})
               $display("FAIL handshake cyc%0d: en/fini/busy=%b%b%b want %b%b1",
                        cyc, pe_en, row_fini, busy, out_ready, out_ready & ev.fini);
            else n_pass++;
            if (out_ready) void'(exp_q.pop_front());
            else stalls++;
         end
         if (!got_done) begin
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      out_ready = 1'b1;
      if (!got_done) begin
         n_checks++;
         $display("FAIL done_timeout: no done within %0d cycles", cyc);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 32; i++) mem[i] = 16'h0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if ({pe_in, pe_cnt, pe_en, row_fini, busy, done, err, mem_in_addr, mem_w_addr} !== '0)
         $display("FAIL reset_state: pe_in=%h cnt=%0d en=%b fini=%b busy=%b done=%b err=%b addr=%h waddr=%h want all 0",
                  pe_in, pe_cnt, pe_en, row_fini, busy, done, err, mem_in_addr, mem_w_addr);
      else n_pass++;
      rst = 1'b1;
   endtask

   task automatic test_single_row();
      clear_mem();
      mem[0] = 16'h0300; mem[1] = 16'h0105; mem[2] = 16'h0407; mem[3] = 16'h0902;
      run_job(5'd0, 5'd7, 5'd1, 0, 0, 0, 1'b0);
   endtask

   task automatic test_empty_row();
      clear_mem();
      mem[0] = 16'h0000; mem[1] = 16'h0100; mem[2] = 16'h0203;
      run_job(5'd0, 5'd3, 5'd2, 0, 0, 0, 1'b0);
   endtask

   task automatic test_stall();
      clear_mem();
      mem[0] = 16'h0300; mem[1] = 16'h0105; mem[2] = 16'h0407; mem[3] = 16'h0902;
      // cycle 4 after start is the pe_cnt=3 stream cycle
      run_job(5'd0, 5'd12, 5'd1, 0, 4, 3, 1'b0);
   endtask

   task automatic test_clamp();
      clear_mem();
      mem[0] = 16'h2000;
      for (int i = 1; i < 32; i++) mem[i] = 16'($urandom);
      mem[29] = 16'h0200;
      run_job(5'd0, 5'd21, 5'd2, 10, 0, 0, 1'b0);
      // a fresh start must clear the sticky error (checked in its first cycle)
      clear_mem();
      mem[4] = 16'h0102; mem[5] = 16'h0333;
      run_job(5'd4, 5'd2, 5'd1, 0, 0, 0, 1'b0);
   endtask

   task automatic test_wrap();
      clear_mem();
      mem[30] = 16'h0300; mem[31] = 16'h1111; mem[0] = 16'h2222; mem[1] = 16'h3333;
      run_job(5'd30, 5'd31, 5'd1, 0, 0, 0, 1'b0);
   endtask

   task automatic test_zero_rows();
      clear_mem();
      run_job(5'd9, 5'd17, 5'd0, 0, 0, 0, 1'b0);
   endtask

   task automatic test_reset_mid_row();
      clear_mem();
      mem[0] = 16'h2000;
      for (int i = 1; i < 32; i++) mem[i] = 16'($urandom);
      @(negedge clk);
      in_base = 5'd0; w_base = 5'd9; num_rows = 5'd1; start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if ({err, pe_en, pe_cnt} !== {1'b1, 1'b1, 5'd3})
         $display("FAIL pre_reset_stream: err=%b en=%b cnt=%0d want 1 1 3", err, pe_en, pe_cnt);
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      #1;
      n_checks++;
      if ({pe_in, pe_cnt, pe_en, row_fini, busy, done, err, mem_in_addr, mem_w_addr} !== '0)
         $display("FAIL reset_mid_row: pe_in=%h cnt=%0d en=%b fini=%b busy=%b done=%b err=%b addr=%h waddr=%h want all 0",
                  pe_in, pe_cnt, pe_en, row_fini, busy, done, err, mem_in_addr, mem_w_addr);
      else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      #1;
      n_checks++;
      if ({busy, done} !== 2'b00) $display("FAIL after_reset: busy=%b done=%b want 00", busy, done);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [4:0] base, a;
      int         rows, n;
      for (int j = 0; j < 8; j++) begin
         clear_mem();
         base = 5'($urandom);
         rows = $urandom_range(1, 4);
         a = base;
         for (int r = 0; r < rows; r++) begin
            n = $urandom_range(0, 5);
            mem[a] = {8'(n), 8'($urandom)};
            for (int k = 1; k <= n; k++) mem[5'(a + k)] = 16'($urandom);
            a = 5'(a + 1 + n);
         end
         run_job(base, 5'($urandom), 5'(rows), 30, 0, 0, 1'b1);
      end
   endtask

   initial begin
      clear_mem();
      test_reset();
      test_single_row();
      test_empty_row();
      test_stall();
      test_clamp();
      test_wrap();
      test_zero_rows();
      test_reset_mid_row();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
